// File: rtl/adc_sample_ram_writer_if.sv
// Sample stream and Avalon-MM write port of the ADC sample RAM writer.
// master: the writer (consumes samples, drives memory); slave: ADC source / memory side.
interface adc_sample_ram_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_sample;
  logic [2:0]  in_channel;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;

  modport master (
    input  in_valid, in_sample, in_channel,
    output in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );

  modport slave (
    output in_valid, in_sample, in_channel,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
  );
endinterface

// File: rtl/adc_sample_ram_writer.sv
// Writes ADC samples as 32-bit words into on-chip memory, NUM_WORDS per start command.
// Define ADC_WRITER_PACK_EN to pack two samples per word (otherwise one sample per word).
//
// state     | meaning
// S_IDLE    | waiting for start, samples refused and counted as drops
// S_CAPTURE | accepting samples and issuing writes
// S_FLUSH   | one cycle writing the pending half-word after an abort
// S_DONE    | NUM_WORDS words issued, done held until next start
module adc_sample_ram_writer #(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter logic [15:0] NUM_WORDS = 16'd40000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  adc_sample_ram_writer_if.master        bus,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    word_count,
  output logic [15:0]                    drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_data_q, mem_data_d;
`ifdef ADC_WRITER_PACK_EN
  logic [15:0] half_q, half_d;
  logic        half_vld_q, half_vld_d;
`endif

  logic [15:0] half_word;
  logic        handshake;
  logic        word_issue;
  logic [16:0] issued_next;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    done_d      = done_q;
    mem_write_d = 1'b0;
    mem_be_d    = mem_be_q;
    mem_data_d  = mem_data_q;
`ifdef ADC_WRITER_PACK_EN
    half_d      = half_q;
    half_vld_d  = half_vld_q;
`endif
    word_issue  = 1'b0;
    half_word   = {1'b0, bus.in_channel, bus.in_sample};
    handshake   = in_ready_q & bus.in_valid;
    // Words already issued (retired + the one in flight) plus the one being issued now.
    issued_next = {1'b0, word_cnt_q} + {16'd0, mem_write_q} + 17'd1;

    // The word whose strobe is on the bus retires at this edge.
    if (mem_write_q) begin
      addr_d     = addr_q + 16'd1;
      word_cnt_d = word_cnt_q + 16'd1;
      if (state_q == S_DONE && (word_cnt_q + 16'd1) == NUM_WORDS) done_d = 1'b1;
    end

    if (bus.in_valid && state_q != S_CAPTURE && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d    = S_CAPTURE;
          addr_d     = BASE_ADDR;
          word_cnt_d = 16'd0;
          drop_cnt_d = 16'd0;
          done_d     = 1'b0;
`ifdef ADC_WRITER_PACK_EN
          half_vld_d = 1'b0;
`endif
        end
      end
      S_CAPTURE: begin
        if (handshake) begin
`ifdef ADC_WRITER_PACK_EN
          if (half_vld_q) begin
            mem_write_d = 1'b1;
            mem_data_d  = {half_word, half_q};
            mem_be_d    = 4'hF;
            half_vld_d  = 1'b0;
            word_issue  = 1'b1;
          end else begin
            half_d     = half_word;
            half_vld_d = 1'b1;
          end
`else
          mem_write_d = 1'b1;
          mem_data_d  = {16'h0000, half_word};
          mem_be_d    = 4'hF;
          word_issue  = 1'b1;
`endif
        end
        // Completing the last word takes precedence over a coincident abort.
        if (word_issue && issued_next == {1'b0, NUM_WORDS}) begin
          state_d = S_DONE;
        end else if (abort) begin
`ifdef ADC_WRITER_PACK_EN
          state_d = half_vld_d ? S_FLUSH : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_FLUSH: begin
`ifdef ADC_WRITER_PACK_EN
        mem_write_d = 1'b1;
        mem_data_d  = {16'h0000, half_q};
        mem_be_d    = 4'b0011;
        half_vld_d  = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_CAPTURE);
    busy_d     = (state_d == S_CAPTURE) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'd0;
      word_cnt_q  <= 16'd0;
      drop_cnt_q  <= 16'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_data_q  <= 32'd0;
`ifdef ADC_WRITER_PACK_EN
      half_q      <= 16'd0;
      half_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      mem_write_q <= mem_write_d;
      mem_be_q    <= mem_be_d;
      mem_data_q  <= mem_data_d;
`ifdef ADC_WRITER_PACK_EN
      half_q      <= half_d;
      half_vld_q  <= half_vld_d;
`endif
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = mem_be_q;
  assign bus.mem_chipselect = mem_write_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_writedata  = mem_data_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign word_count         = word_cnt_q;
  assign drop_count         = drop_cnt_q;

endmodule

// File: tb/tb_adc_sample_ram_writer.sv
// Scoreboard bench for adc_sample_ram_writer: transaction-level model predicts every memory write,
// a monitor compares the writes as they appear on the bus.
module tb_adc_sample_ram_writer;
  localparam logic [15:0] BASE = 16'h0010;
  localparam int NW = 4;
`ifdef ADC_WRITER_PACK_EN
  localparam int SPW = 2;
`else
  localparam int SPW = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [15:0] word_count, drop_count;

  adc_sample_ram_writer_if bus();

  adc_sample_ram_writer #(.BASE_ADDR(BASE), .NUM_WORDS(16'(NW))) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference model: capture status at transaction level
  bit          m_cap = 0;
  int          m_words = 0;
  int          m_drops = 0;
  bit          m_done = 0;
  logic [15:0] m_pend[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (bus.mem_write) begin
      check("chipselect_eq_write", 32'(bus.mem_chipselect), 32'd1);
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %h data %h, no write predicted", bus.mem_address,
                 bus.mem_writedata);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("mem_address", 32'(bus.mem_address), 32'(e.addr));
        check("mem_writedata", bus.mem_writedata, e.data);
        check("mem_byteenable", 32'(bus.mem_byteenable), 32'(e.be));
      end
    end
  end

  task automatic push_word(logic [31:0] data, logic [3:0] be, bit counts_to_done);
    exp_t e;
    e.addr = BASE + 16'(m_words);
    e.data = data;
    e.be   = be;
    expq.push_back(e);
    m_words++;
    if (counts_to_done && m_words == NW) begin
      m_cap  = 0;
      m_done = 1;
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_words = 0; m_drops = 0; m_done = 0;
    m_pend.delete();
    expq.delete();
  endtask

  // One clock cycle of stimulus, entered and left at a falling edge.
  task automatic cycle(bit v, logic [11:0] s, logic [2:0] ch, bit st, bit ab);
    logic [15:0] hw;
    bit was_cap;
    check("in_ready", 32'(bus.in_ready), 32'(m_cap));
    bus.in_valid   = v;
    bus.in_sample  = s;
    bus.in_channel = ch;
    start          = st;
    abort          = ab;
    hw      = {1'b0, ch, s};
    was_cap = m_cap;
    if (v && reset_n) begin
      if (m_cap) begin
        m_pend.push_back(hw);
        if (m_pend.size() == SPW) begin
          if (SPW == 2) push_word({m_pend[1], m_pend[0]}, 4'hF, 1);
          else push_word({16'h0000, m_pend[0]}, 4'hF, 1);
          m_pend.delete();
        end
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
    if (reset_n) begin
      if (ab) begin
        if (m_cap) begin
          if (m_pend.size() != 0) push_word({16'h0000, m_pend[0]}, 4'b0011, 0);
          m_pend.delete();
          m_cap = 0;
        end
      end else if (st && !was_cap) begin
        m_cap = 1; m_words = 0; m_drops = 0; m_done = 0;
        m_pend.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic settle(string tag);
    idle();
    idle();
    check({tag, "_word_count"}, 32'(word_count), 32'(m_words));
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_busy"}, 32'(busy), 32'(m_cap));
    check({tag, "_drop_count"}, 32'(drop_count), 32'(m_drops));
  endtask

  function automatic logic all_outputs_or();
    return |{bus.in_ready, bus.mem_address, bus.mem_byteenable, bus.mem_chipselect, bus.mem_write,
             bus.mem_writedata, busy, done, word_count, drop_count};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sample = 12'h000;
    bus.in_channel = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", 32'(all_outputs_or()), 32'd0);
    reset_n = 1'b1;
    idle();

    // Samples offered while idle are refused and counted
    repeat (5) cycle(1'b1, 12'h5A5, 3'd1, 1'b0, 1'b0);
    settle("idle_drops");

    // Directed capture: channel 2, codes 1..NW*SPW
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= NW * SPW; k++) cycle(1'b1, 12'(k), 3'd2, 1'b0, 1'b0);
    settle("directed");

    // Last word timing: in_ready drops with the last handshake, done follows the strobe
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < NW * SPW; k++) cycle(1'b1, 12'(12'h100 + k), 3'd5, 1'b0, 1'b0);
    check("last_strobe_high", 32'(bus.mem_write), 32'd1);
    check("done_low_during_last", 32'(done), 32'd0);
    check("ready_low_after_last", 32'(bus.in_ready), 32'd0);
    idle();
    check("strobe_single_cycle", 32'(bus.mem_write), 32'd0);
    check("done_after_strobe", 32'(done), 32'd1);
    settle("boundary");

    // start and abort together: nothing happens
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b1);
    settle("start_abort");

    // start during capture must not restart addressing
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 12'h0A1, 3'd3, 1'b0, 1'b0);
    cycle(1'b1, 12'h0A2, 3'd3, 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 12'h0A3, 3'd3, 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 3'd0, 1'b0, 1'b1);
    settle("restart_ignored");

    // Abort with an odd number of samples (flushes a half-word when packing)
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 12'h111, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 12'h222, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 12'h333, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 12'h000, 3'd0, 1'b0, 1'b1);
    settle("abort_flush");

    // abort while idle has no effect
    cycle(1'b0, 12'h000, 3'd0, 1'b0, 1'b1);
    settle("abort_idle");

    // Reset in the middle of a capture
    cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 12'h7E1, 3'd4, 1'b0, 1'b0);
    cycle(1'b1, 12'h7E2, 3'd4, 1'b0, 1'b0);
    cycle(1'b1, 12'h7E3, 3'd4, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs_zero", 32'(all_outputs_or()), 32'd0);
    model_reset();
    @(negedge clk);
    idle();
    idle();
    reset_n = 1'b1;
    repeat (3) idle();
    settle("after_reset");

    // Randomized captures with gaps, drops, stray starts and occasional aborts
    for (int r = 0; r < 12; r++) begin
      int n_drop;
      n_drop = $urandom_range(0, 3);
      for (int d = 0; d < n_drop; d++) cycle(1'b1, 12'($urandom), 3'($urandom), 1'b0, 1'b0);
      idle();
      cycle(1'b0, 12'h000, 3'd0, 1'b1, 1'b0);
      for (int k = 0; k < 60 && m_cap; k++) begin
        if ($urandom_range(0, 19) == 0)
          cycle(1'b0, 12'h000, 3'd0, 1'b0, 1'b1);
        else
          cycle($urandom_range(0, 3) != 0, 12'($urandom), 3'($urandom),
                $urandom_range(0, 9) == 0, 1'b0);
      end
      settle("random");
    end

    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
